hazard_forward_unit: RTL

- Generates the 2-bit select codes that drive the 5-bit/32-bit 4:1 operand muxes in EX, and the load-use stall for the 5-stage pipeline.
- Keeps a shadow pipeline of destination register numbers and write/load flags for EX, MEM and WB.
- Compares the ID-stage source registers against that shadow pipeline and registers the resulting select codes so they are valid when the instruction reaches EX.

---
 rtl/hazard_forward_unit_pkg.sv | 20 ++
 rtl/hazard_forward_unit_fwd_select.sv | 43 ++++
 rtl/hazard_forward_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit: register width,
// EX operand-mux select codes and the shadow-pipeline slot record.
package hazard_forward_unit_pkg;

   localparam int REG_W = 5;

   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_EXMEM  = 2'b01;
   localparam logic [1:0] FWD_MEMWB  = 2'b10;
   localparam logic [1:0] FWD_WBHOLD = 2'b11;

   typedef struct packed {
      logic             we;
      logic             load;
      logic [REG_W-1:0] dst;
   } slot_t;

   localparam slot_t BUBBLE = '0;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority comparator for one ID source register against the EX/MEM/WB
// shadow slots; the nearest producer wins.
module fwd_select
   import hazard_forward_unit_pkg::*;
#(
   parameter bit R0_HARDWIRED = 1'b1
) (
   input  logic [REG_W-1:0] src,
   input  logic             use_src,
   input  logic [2:0]       slot_we,
   input  logic [REG_W-1:0] ex_dst,
   input  logic [REG_W-1:0] mem_dst,
   input  logic [REG_W-1:0] wb_dst,
   output logic [1:0]       sel,
   output logic             ex_hit
);

   logic match_ex;
   logic match_mem;
   logic match_wb;
   logic src_is_r0;

   // slot_we bit order is {wb, mem, ex}
   assign src_is_r0 = R0_HARDWIRED && (src == '0);
   assign match_ex  = slot_we[0] && (ex_dst == src) && !src_is_r0;
   assign match_mem = slot_we[1] && (mem_dst == src) && !src_is_r0;
   assign match_wb  = slot_we[2] && (wb_dst == src) && !src_is_r0;

   always_comb begin
      sel    = FWD_RF;
      ex_hit = use_src && match_ex;
      if (use_src) begin
         if (match_ex) begin
            sel = FWD_EXMEM;
         end else if (match_mem) begin
            sel = FWD_MEMWB;
         end else if (match_wb) begin
            sel = FWD_WBHOLD;
         end
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding-select and load-use stall generator for the 5-stage pipeline;
// tracks destination registers of EX/MEM/WB in a shadow pipeline.
module hazard_forward_unit #(
   parameter int REG_W        = hazard_forward_unit_pkg::REG_W,
   parameter bit R0_HARDWIRED = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             flush,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic [REG_W-1:0] id_dst,
   input  logic             id_we,
   input  logic             id_is_load,
   output logic             stall,
   output logic [1:0]       ex_fwd_a_sel,
   output logic [1:0]       ex_fwd_b_sel,
   output logic [REG_W-1:0] ex_dst,
   output logic [REG_W-1:0] mem_dst,
   output logic [REG_W-1:0] wb_dst
);

   import hazard_forward_unit_pkg::*;

   slot_t      ex_slot;
   slot_t      mem_slot;
   slot_t      wb_slot;
   logic [1:0] sel_a;
   logic [1:0] sel_b;
   logic       hit_a;
   logic       hit_b;
   logic [2:0] slot_we;

   assign slot_we = {wb_slot.we, mem_slot.we, ex_slot.we};

   fwd_select #(.R0_HARDWIRED(R0_HARDWIRED)) u_sel_a (
      .src     (id_rs),
      .use_src (id_use_rs),
      .slot_we (slot_we),
      .ex_dst  (ex_slot.dst),
      .mem_dst (mem_slot.dst),
      .wb_dst  (wb_slot.dst),
      .sel     (sel_a),
      .ex_hit  (hit_a)
   );

   fwd_select #(.R0_HARDWIRED(R0_HARDWIRED)) u_sel_b (
      .src     (id_rt),
      .use_src (id_use_rt),
      .slot_we (slot_we),
      .ex_dst  (ex_slot.dst),
      .mem_dst (mem_slot.dst),
      .wb_dst  (wb_slot.dst),
      .sel     (sel_b),
      .ex_hit  (hit_b)
   );

   // A squashed ID instruction can never need the load result, so flush masks the stall
   assign stall = !flush && ex_slot.we && ex_slot.load && (hit_a || hit_b);

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_slot      <= BUBBLE;
         mem_slot     <= BUBBLE;
         wb_slot      <= BUBBLE;
         ex_fwd_a_sel <= FWD_RF;
         ex_fwd_b_sel <= FWD_RF;
      end else if (!hold) begin
         wb_slot  <= mem_slot;
         mem_slot <= ex_slot;
         if (stall || flush) begin
            ex_slot      <= BUBBLE;
            ex_fwd_a_sel <= FWD_RF;
            ex_fwd_b_sel <= FWD_RF;
         end else begin
            ex_slot      <= '{we: id_we, load: id_is_load, dst: id_dst};
            ex_fwd_a_sel <= sel_a;
            ex_fwd_b_sel <= sel_b;
         end
      end
   end

   assign ex_dst  = ex_slot.dst;
   assign mem_dst = mem_slot.dst;
   assign wb_dst  = wb_slot.dst;

endmodule
